pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives PC write-enable, IF/ID hold and flush, ID/EX clear, and a global pipeline enable.
- Detects load-use hazards and taken-branch flushes, sequences halt draining, and supports continuous-run and single-step execution for the debug unit.
- Sits beside the ID stage; ID/EX `clear` and the global enable come from here.

Parameters:
- DRAIN_CYCLES, 3, enabled cycles after a halt leaves ID before halted asserts (EX, MEM, WB); legal range 1..15.
- CNT_W, 32, width of the executed-cycle counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; leaves IDLE.
- step_mode  in  1  1 = advance only on step edges; 0 = free-run.
- step  in  1  debug step request, level; a rising edge grants one enabled cycle.
- rsID  in  5  rs field of the instruction in ID.
- rtID  in  5  rt field of the instruction in ID.
- usesRsID  in  1  ID instruction reads rs.
- usesRtID  in  1  ID instruction reads rt.
- MemtoRegEX  in  1  instruction in EX is a load (ID/EX output).
- rtEX  in  5  load destination in EX (ID/EX output).
- BranchTakenID  in  1  branch in ID resolved taken.
- HaltID  in  1  ID instruction is HALT.
- pipe_en  out  1  global enable for all pipeline registers, PC and register file write.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_clear  out  1  IF/ID flush to NOP.
- id_ex_clear  out  1  drives ID/EX `clear` (bubble insert).
- halted  out  1  registered; pipeline drained after HALT.
- cycle_count  out  CNT_W  registered count of enabled cycles.

Behaviour:
- States: IDLE, RUN, DRAIN, HALTED; 4-bit drain counter `dcnt`; step-edge register `step_q`.
- Reset (sync), taking effect at the next posedge: state=IDLE, dcnt=0, step_q=0, halted=0, cycle_count=0.
  - Reset wins over every other input, including mid-DRAIN and in HALTED.
- Step grant:
  - grant = (step & ~step_q) when step_mode=1, else 1.
  - step_q <= step every cycle except reset.
- pipe_en = grant & (state==RUN | state==DRAIN).
  - When pipe_en=0: pc_write, if_id_write, if_id_clear and id_ex_clear are all 0, state/dcnt/cycle_count hold.
  - HALTED is the one exception: see below.
- cycle_count increments by 1 on every pipe_en=1 cycle; wraps modulo 2^CNT_W.
- IDLE:
  - All outputs 0 except if_id_write=0 and pc_write=0.
  - start=1 → RUN next cycle; start is ignored in any other state.
- RUN, with pipe_en=1:
  - load_use = MemtoRegEX & (rtEX!=0) & ((usesRsID & rsID==rtEX) | (usesRtID & rtID==rtEX)).
  - load_use=1: pc_write=0, if_id_write=0, id_ex_clear=1, if_id_clear=0. Branch and halt in ID are ignored this cycle (re-evaluated next cycle).
  - else if HaltID=1: pc_write=0, if_id_write=1, if_id_clear=1, id_ex_clear=0. The HALT itself advances to EX. → DRAIN with dcnt=DRAIN_CYCLES-1.
  - else if BranchTakenID=1: pc_write=1, if_id_write=1, if_id_clear=1, id_ex_clear=0.
  - else: pc_write=1, if_id_write=1, clears=0.
  - A single load produces exactly one bubble: the next cycle MemtoRegEX=0.
- DRAIN, with pipe_en=1:
  - pc_write=0, if_id_write=1, if_id_clear=1, id_ex_clear=1 (NOPs enter behind the HALT).
  - dcnt==0 → HALTED, halted<=1; else dcnt<=dcnt-1.
- HALTED:
  - pipe_en=0, pc_write=0, all other strobes 0, halted=1.
  - Left only by reset; step and start are ignored.
- Latency:
  - Strobes are combinational from state plus ID/EX inputs in the same cycle.
  - halted asserts exactly DRAIN_CYCLES enabled cycles after the cycle HaltID was accepted.

Test Plan:
- Load-use: RUN, free-run; MemtoRegEX=1, rtEX=5, rsID=5, usesRsID=1 → one cycle with pc_write=0, if_id_write=0, id_ex_clear=1. Next cycle MemtoRegEX=0 → normal strobes; cycle_count +2. Repeat with rtEX=0 → no stall.
- Branch vs. stall: BranchTakenID=1, no hazard → if_id_clear=1, pc_write=1. BranchTakenID=1 together with load_use → stall strobes only, if_id_clear=0.
- Halt drain, DRAIN_CYCLES=3: HaltID=1 at cycle N → pc_write=0 from N; halted=1 after the posedge ending N+3; cycle_count frozen afterwards; start and step ignored.
- Step mode: step_mode=1, step held high 5 cycles → exactly 1 pipe_en cycle, cycle_count +1. Toggle step 3 times → 3 enabled cycles. No edge → strobes all 0, state holds.
- Reset mid-DRAIN: reset=1 with dcnt=1 → at the next posedge state=IDLE, halted=0, cycle_count=0, pipe_en=0. start → RUN.
- IDLE gating: hazards, BranchTakenID and HaltID asserted before start → no strobes, cycle_count stays 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes, halt draining and debug single-step gating.
module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [4:0]       rsID,
    input  logic [4:0]       rtID,
    input  logic             usesRsID,
    input  logic             usesRtID,
    input  logic             MemtoRegEX,
    input  logic [4:0]       rtEX,
    input  logic             BranchTakenID,
    input  logic             HaltID,
    output logic             pipe_en,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_clear,
    output logic             id_ex_clear,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic             step_q, step_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic grant;
    logic load_use;

    always_comb begin
        grant    = step_mode ? (step & ~step_q) : 1'b1;
        load_use = MemtoRegEX & (rtEX != 5'd0) &
                   ((usesRsID & (rsID == rtEX)) | (usesRtID & (rtID == rtEX)));

        pipe_en     = grant & ((state_q == S_RUN) | (state_q == S_DRAIN));
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_clear = 1'b0;
        id_ex_clear = 1'b0;

        state_d  = state_q;
        dcnt_d   = dcnt_q;
        step_d   = step;
        halted_d = halted_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (pipe_en) begin
                    // Stall outranks branch and halt; both are re-seen once the bubble clears.
                    if (load_use) begin
                        id_ex_clear = 1'b1;
                    end else if (HaltID) begin
                        if_id_write = 1'b1;
                        if_id_clear = 1'b1;
                        state_d     = S_DRAIN;
                        dcnt_d      = 4'(DRAIN_CYCLES - 1);
                    end else if (BranchTakenID) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        if_id_clear = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (pipe_en) begin
                    if_id_write = 1'b1;
                    if_id_clear = 1'b1;
                    id_ex_clear = 1'b1;
                    if (dcnt_q == 4'd0) begin
                        state_d  = S_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q - 4'd1;
                    end
                end
            end
            default: begin
                halted_d = 1'b1;
            end
        endcase

        if (pipe_en) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dcnt_q   <= '0;
            step_q   <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            step_q   <= step_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign halted      = halted_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random stimulus, every cycle
// compared against a behavioural model of the controller.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, step_mode, step;
    logic [4:0]  rsID, rtID, rtEX;
    logic        usesRsID, usesRtID, MemtoRegEX, BranchTakenID, HaltID;
    logic        pipe_en, pc_write, if_id_write, if_id_clear, id_ex_clear, halted;
    logic [31:0] cycle_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model state: started/halting/halted flags, enabled cycles left before halted,
    // previous step level, count of enabled cycles.
    bit          m_started, m_draining, m_halted, m_prev_step;
    int          m_left;
    logic [31:0] m_count;

    pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
        .rsID(rsID), .rtID(rtID), .usesRsID(usesRsID), .usesRtID(usesRtID),
        .MemtoRegEX(MemtoRegEX), .rtEX(rtEX), .BranchTakenID(BranchTakenID),
        .HaltID(HaltID), .pipe_en(pipe_en), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_clear(if_id_clear),
        .id_ex_clear(id_ex_clear), .halted(halted), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_started = 0; m_draining = 0; m_halted = 0; m_prev_step = 0;
        m_left = 0; m_count = '0;
    endtask

    task automatic quiet_inputs();
        reset = 0; start = 0; step = 0;
        rsID = '0; rtID = '0; rtEX = '0;
        usesRsID = 0; usesRtID = 0; MemtoRegEX = 0; BranchTakenID = 0; HaltID = 0;
    endtask

    // Called at a negedge with inputs already driven; checks, then advances one clock.
    task automatic run_cycle();
        bit grant, en, hz;
        bit e_pc, e_ifw, e_ifc, e_idc;
        #1;
        grant = step_mode ? (step && !m_prev_step) : 1'b1;
        en    = grant && m_started && !m_halted;
        hz    = MemtoRegEX && (rtEX != 0) &&
                ((usesRsID && rsID == rtEX) || (usesRtID && rtID == rtEX));
        {e_pc, e_ifw, e_ifc, e_idc} = 4'b0000;
        if (en) begin
            if (m_draining)         {e_pc, e_ifw, e_ifc, e_idc} = 4'b0111;
            else if (hz)            {e_pc, e_ifw, e_ifc, e_idc} = 4'b0001;
            else if (HaltID)        {e_pc, e_ifw, e_ifc, e_idc} = 4'b0110;
            else if (BranchTakenID) {e_pc, e_ifw, e_ifc, e_idc} = 4'b1110;
            else                    {e_pc, e_ifw, e_ifc, e_idc} = 4'b1100;
        end
        chk("pipe_en", 32'(pipe_en), 32'(en));
        chk("pc_write", 32'(pc_write), 32'(e_pc));
        chk("if_id_write", 32'(if_id_write), 32'(e_ifw));
        chk("if_id_clear", 32'(if_id_clear), 32'(e_ifc));
        chk("id_ex_clear", 32'(id_ex_clear), 32'(e_idc));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("cycle_count", cycle_count, m_count);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            m_prev_step = step;
            if (!m_started && start) m_started = 1;
            if (en) begin
                m_count = m_count + 1;
                if (m_draining) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_halted = 1;
                        m_draining = 0;
                    end
                end else if (!hz && HaltID) begin
                    m_draining = 1;
                    m_left = 3;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        quiet_inputs();
        step_mode = 0;
        reset = 1;
        model_reset();
        @(posedge clk); @(posedge clk); @(negedge clk);
        run_cycle();
        reset = 0;
        chk("reset_count", cycle_count, 32'd0);

        // Hazards, branch and halt presented before start must do nothing.
        MemtoRegEX = 1; rtEX = 5'd5; rsID = 5'd5; usesRsID = 1; BranchTakenID = 1; HaltID = 1;
        run_n(3);
        chk("idle_count", cycle_count, 32'd0);
        quiet_inputs();
        start = 1; run_cycle(); start = 0;
        run_n(2);

        // Load-use stall followed by the normal cycle.
        MemtoRegEX = 1; rtEX = 5'd5; rsID = 5'd5; usesRsID = 1; run_cycle();
        MemtoRegEX = 0; run_n(1);
        // rtEX = 0 never stalls.
        MemtoRegEX = 1; rtEX = 5'd0; rsID = 5'd0; run_cycle();
        // rt-side hazard.
        quiet_inputs(); MemtoRegEX = 1; rtEX = 5'd9; rtID = 5'd9; usesRtID = 1; run_cycle();
        quiet_inputs(); BranchTakenID = 1; run_cycle();
        MemtoRegEX = 1; rtEX = 5'd7; rsID = 5'd7; usesRsID = 1; run_cycle();
        quiet_inputs(); run_cycle();

        // Single-step: held level is one grant, each new edge is one more.
        step_mode = 1; step = 0; run_cycle();
        step = 1; run_n(5);
        for (int i = 0; i < 3; i++) begin
            step = 0; run_cycle();
            step = 1; run_cycle();
        end
        step = 0; run_n(3);
        step_mode = 0;

        // Halt drain in free-run, then start/step ignored while halted.
        HaltID = 1; run_cycle(); HaltID = 0;
        run_n(3);
        chk("halted_after_drain", 32'(halted), 32'd1);
        start = 1; step_mode = 1; step = 1; run_cycle();
        start = 0; step = 0; run_cycle(); step = 1; run_cycle();
        step_mode = 0; step = 0; run_n(2);

        // Reset while draining with one cycle left in the counter.
        reset = 1; run_cycle(); reset = 0;
        start = 1; run_cycle(); start = 0;
        HaltID = 1; run_cycle(); HaltID = 0;
        run_cycle();
        reset = 1; run_cycle(); reset = 0;
        chk("mid_drain_rst_halted", 32'(halted), 32'd0);
        chk("mid_drain_rst_count", cycle_count, 32'd0);
        run_cycle();
        start = 1; run_cycle(); start = 0;
        run_n(2);

        // Random traffic; small register range to make hazards common.
        for (int i = 0; i < 2000; i++) begin
            reset         = ($urandom_range(0, 60) == 0);
            start         = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) step_mode = ~step_mode;
            step          = 1'($urandom_range(0, 1));
            rsID          = 5'($urandom_range(0, 3));
            rtID          = 5'($urandom_range(0, 3));
            rtEX          = 5'($urandom_range(0, 3));
            usesRsID      = 1'($urandom_range(0, 1));
            usesRtID      = 1'($urandom_range(0, 1));
            MemtoRegEX    = ($urandom_range(0, 2) == 0);
            BranchTakenID = ($urandom_range(0, 3) == 0);
            HaltID        = ($urandom_range(0, 24) == 0);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
